// File: rtl/stream_source_switch.sv
// Frame-aligned selector between two pixel streams (A = raw, B = processed).
// Source changes only at frame end; output passes through a 2-entry FWFT buffer.
module stream_source_switch #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_req,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  input  logic              a_sof,
  input  logic              a_eof,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  input  logic              b_sof,
  input  logic              b_eof,
  output logic              b_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_sof,
  output logic              m_eof,
  input  logic              m_ready,
  output logic              active_src,
  output logic              switch_pending,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [0:0]       ST_WAIT_SOF = 1'b0;
  localparam logic [0:0]       ST_PASS     = 1'b1;
  localparam int               ENT_W       = DATA_W + 2;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic             active_src_q, active_src_d;
  logic             switch_pending_q, switch_pending_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             ready_en_q, ready_en_d;
  logic [ENT_W-1:0] mem0_q, mem0_d;
  logic [ENT_W-1:0] mem1_q, mem1_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic              act_ready_s;
  logic              act_valid_s;
  logic              act_sof_s;
  logic              act_eof_s;
  logic [DATA_W-1:0] act_data_s;
  logic [ENT_W-1:0]  entry_s;
  logic [ENT_W-1:0]  head_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              m_valid_s;

  // Readies depend only on registered state; the inactive source is always drained.
  assign act_ready_s = ready_en_q & (count_q < 2'd2);
  assign a_ready     = active_src_q ? ready_en_q : act_ready_s;
  assign b_ready     = active_src_q ? act_ready_s : ready_en_q;

  assign act_valid_s = active_src_q ? b_valid : a_valid;
  assign act_sof_s   = active_src_q ? b_sof   : a_sof;
  assign act_eof_s   = active_src_q ? b_eof   : a_eof;
  assign act_data_s  = active_src_q ? b_data  : a_data;
  assign entry_s     = {act_sof_s, act_eof_s, act_data_s};

  assign accept_s  = act_valid_s & act_ready_s;
  assign push_s    = accept_s & ((state_q == ST_PASS) | act_sof_s);
  assign head_s    = rd_ptr_q ? mem1_q : mem0_q;
  assign m_valid_s = (count_q != 2'd0);
  assign pop_s     = m_valid_s & m_ready;

  assign m_valid        = m_valid_s;
  assign m_data         = head_s[DATA_W-1:0];
  assign m_eof          = head_s[DATA_W];
  assign m_sof          = head_s[DATA_W+1];
  assign active_src     = active_src_q;
  assign switch_pending = switch_pending_q;
  assign frame_cnt      = frame_cnt_q;

  // Next-state: frame FSM, buffer pointers/occupancy and delivered-frame counter.
  always_comb begin
    state_d          = state_q;
    active_src_d     = active_src_q;
    mem0_d           = mem0_q;
    mem1_d           = mem1_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    frame_cnt_d      = frame_cnt_q;
    ready_en_d       = 1'b1;
    switch_pending_d = (state_q == ST_PASS) && (sel_req != active_src_q);

    if (push_s) begin
      if (wr_ptr_q) begin
        mem1_d = entry_s;
      end else begin
        mem0_d = entry_s;
      end
      wr_ptr_d = ~wr_ptr_q;
      // A single-beat frame in WAIT_SOF hits the frame-end rule in the same cycle.
      if (act_eof_s && (sel_req != active_src_q)) begin
        active_src_d = ~active_src_q;
        state_d      = ST_WAIT_SOF;
      end else begin
        state_d = ST_PASS;
      end
    end else begin
      state_d = state_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
      if (head_s[DATA_W]) begin
        frame_cnt_d = frame_cnt_q + CNT_ONE;
      end else begin
        frame_cnt_d = frame_cnt_q;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset; reset flushes the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_WAIT_SOF;
      active_src_q     <= 1'b0;
      switch_pending_q <= 1'b0;
      frame_cnt_q      <= '0;
      ready_en_q       <= 1'b0;
      mem0_q           <= '0;
      mem1_q           <= '0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      count_q          <= 2'd0;
    end else begin
      state_q          <= state_d;
      active_src_q     <= active_src_d;
      switch_pending_q <= switch_pending_d;
      frame_cnt_q      <= frame_cnt_d;
      ready_en_q       <= ready_en_d;
      mem0_q           <= mem0_d;
      mem1_q           <= mem1_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

endmodule
